// File: rtl/sntc_ldpc_cword_assembler.sv
// Packs a W-bit valid/ready beat stream into one NN-bit codeword held for the LDPC syndrome stage.
// Optional in_last framing check: define SNTC_LDPC_ASM_FRAME_CHK_EN.
module sntc_ldpc_cword_assembler #(
    parameter int NN = 'h000d0,
    parameter int W  = 16,
    localparam int BEATS = (NN + W - 1) / W,
    localparam int CNT_W = $clog2(BEATS + 1)
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             clr,
    input  logic [W-1:0]     in_data,
    input  logic             in_valid,
    input  logic             in_last,
    output logic             in_ready,
    output logic [NN-1:0]    y_nr_out,
    output logic             y_valid,
    input  logic             y_ready,
    output logic [CNT_W-1:0] beat_cnt,
    output logic             frame_err
);

    typedef enum logic {FILL, FULL} state_t;

    localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(BEATS - 1);

    state_t state;
    logic   frame_bad;

    // A full word frees the input side only in the cycle the consumer takes it.
    assign in_ready = (state == FILL) || y_ready;

`ifdef SNTC_LDPC_ASM_FRAME_CHK_EN
    logic is_final;
    // During a handoff the incoming beat is beat 0 of the next word.
    assign is_final  = (state == FULL) ? (BEATS == 1) : (beat_cnt == LAST_BEAT);
    assign frame_bad = (in_last != is_final);
`else
    logic unused_last;
    assign unused_last = in_last;
    assign frame_bad   = 1'b0;
`endif

    // Writes beat k LSB-first; bits past NN on the final beat fall away.
    function automatic logic [NN-1:0] place_beat(input logic [NN-1:0] word,
                                                 input logic [CNT_W-1:0] k,
                                                 input logic [W-1:0] data);
        logic [NN-1:0] w;
        w = word;
        for (int i = 0; i < NN; i++) begin
            if ((i / W) == int'(k)) w[i] = data[i % W];
        end
        return w;
    endfunction

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state     <= FILL;
            beat_cnt  <= '0;
            y_nr_out  <= '0;
            y_valid   <= 1'b0;
            frame_err <= 1'b0;
        end else if (clr) begin
            state     <= FILL;
            beat_cnt  <= '0;
            y_nr_out  <= '0;
            y_valid   <= 1'b0;
            frame_err <= 1'b0;
        end else begin
            frame_err <= 1'b0;
            if (state == FILL) begin
                if (in_valid) begin
                    if (frame_bad) begin
                        beat_cnt  <= '0;
                        frame_err <= 1'b1;
                    end else begin
                        y_nr_out <= place_beat(y_nr_out, beat_cnt, in_data);
                        if (beat_cnt == LAST_BEAT) begin
                            beat_cnt <= '0;
                            state    <= FULL;
                            y_valid  <= 1'b1;
                        end else begin
                            beat_cnt <= beat_cnt + CNT_W'(1);
                        end
                    end
                end
            end else if (y_ready) begin
                if (in_valid && !frame_bad) begin
                    y_nr_out <= place_beat(y_nr_out, '0, in_data);
                    if (BEATS == 1) begin
                        state   <= FULL;
                        y_valid <= 1'b1;
                    end else begin
                        state    <= FILL;
                        y_valid  <= 1'b0;
                        beat_cnt <= CNT_W'(1);
                    end
                end else begin
                    // Handoff completes; a misframed beat riding on it is dropped.
                    state     <= FILL;
                    y_valid   <= 1'b0;
                    frame_err <= in_valid;
                end
            end
        end
    end

endmodule

// File: tb/tb_sntc_ldpc_cword_assembler.sv
// Randomised and directed checks of the codeword assembler against a beat-list model.
module tb_sntc_ldpc_cword_assembler;
    localparam int NN = 208;
    localparam int W = 16;
    localparam int BEATS = 13;
`ifdef SNTC_LDPC_ASM_FRAME_CHK_EN
    localparam bit FCHK = 1'b1;
`else
    localparam bit FCHK = 1'b0;
`endif

    logic clk = 1'b0;
    logic rstn, clr, in_valid, in_last, y_ready;
    logic [W-1:0] in_data;
    logic in_ready, y_valid, frame_err;
    logic [NN-1:0] y_nr_out;
    logic [3:0] beat_cnt;

    logic s_clr, s_in_valid, s_in_last, s_in_ready, s_y_valid, s_y_ready, s_ferr;
    logic [15:0] s_in_data;
    logic [19:0] s_y;
    logic [1:0] s_cnt;

    always #5 clk = ~clk;

    sntc_ldpc_cword_assembler #(.NN(NN), .W(W)) dut (
        .clk(clk), .rstn(rstn), .clr(clr), .in_data(in_data), .in_valid(in_valid),
        .in_last(in_last), .in_ready(in_ready), .y_nr_out(y_nr_out), .y_valid(y_valid),
        .y_ready(y_ready), .beat_cnt(beat_cnt), .frame_err(frame_err));

    sntc_ldpc_cword_assembler #(.NN(20), .W(16)) dut_small (
        .clk(clk), .rstn(rstn), .clr(s_clr), .in_data(s_in_data), .in_valid(s_in_valid),
        .in_last(s_in_last), .in_ready(s_in_ready), .y_nr_out(s_y), .y_valid(s_y_valid),
        .y_ready(s_y_ready), .beat_cnt(s_cnt), .frame_err(s_ferr));

    int cmp_n = 0;
    int err_n = 0;

    bit m_valid, m_ferr;
    int m_cnt;
    logic [W-1:0] m_beats[BEATS];

    task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
        cmp_n++;
        if (act !== exp) begin
            err_n++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    function automatic logic [NN-1:0] m_word();
        logic [NN-1:0] w;
        for (int i = 0; i < NN; i++) w[i] = m_beats[i / W][i % W];
        return w;
    endfunction

    task automatic m_reset();
        m_valid = 1'b0;
        m_ferr = 1'b0;
        m_cnt = 0;
    endtask

    task automatic model_clock();
        bit acc, fin;
        acc = in_valid && (!m_valid || y_ready);
        if (clr) begin
            m_reset();
            return;
        end
        m_ferr = 1'b0;
        if (m_valid && y_ready) m_valid = 1'b0;
        if (acc) begin
            fin = (m_cnt == BEATS - 1);
            if (FCHK && (in_last != fin)) begin
                m_cnt = 0;
                m_ferr = 1'b1;
            end else begin
                m_beats[m_cnt] = in_data;
                if (fin) begin
                    m_valid = 1'b1;
                    m_cnt = 0;
                end else begin
                    m_cnt++;
                end
            end
        end
    endtask

    task automatic compare();
        chk("y_valid", y_valid, m_valid);
        chk("beat_cnt", beat_cnt, m_cnt);
        chk("in_ready", in_ready, !m_valid || y_ready);
        chk("frame_err", frame_err, m_ferr);
        if (m_valid) chk("y_nr_out", y_nr_out, m_word());
    endtask

    task automatic step();
        @(posedge clk);
        model_clock();
        @(negedge clk);
        compare();
    endtask

    task automatic beat(input logic [W-1:0] d);
        in_valid = 1'b1;
        in_data = d;
        in_last = (m_cnt == BEATS - 1);
        step();
    endtask

    task automatic idle();
        in_valid = 1'b0;
        step();
    endtask

    initial begin
        rstn = 1'b0; clr = 1'b0; in_valid = 1'b0; in_data = '0; in_last = 1'b0; y_ready = 1'b1;
        s_clr = 1'b0; s_in_valid = 1'b0; s_in_data = '0; s_in_last = 1'b0; s_y_ready = 1'b1;
        m_reset();
        for (int i = 0; i < BEATS; i++) m_beats[i] = '0;
        repeat (2) @(negedge clk);
        rstn = 1'b1;
        chk("rst_y_valid", y_valid, 1'b0);
        chk("rst_y_nr_out", y_nr_out, '0);
        chk("rst_beat_cnt", beat_cnt, 4'd0);
        chk("rst_in_ready", in_ready, 1'b1);
        chk("rst_frame_err", frame_err, 1'b0);

        // Beat index as data, consumer always ready
        for (int k = 0; k < BEATS; k++) begin
            beat(W'(k));
            if (k == BEATS - 2) chk("seq_not_yet_valid", y_valid, 1'b0);
        end
        chk("seq_valid", y_valid, 1'b1);
        chk("seq_lo", y_nr_out[15:0], 16'd0);
        chk("seq_b1", y_nr_out[31:16], 16'd1);
        chk("seq_hi", y_nr_out[207:192], 16'd12);
        idle();
        chk("seq_drop", y_valid, 1'b0);

        // Backpressure then same-cycle handoff
        y_ready = 1'b0;
        for (int k = 0; k < BEATS; k++) beat(W'($urandom));
        in_valid = 1'b0;
        for (int c = 0; c < 20; c++) step();
        chk("bp_in_ready", in_ready, 1'b0);
        chk("bp_valid", y_valid, 1'b1);
        y_ready = 1'b1;
        beat(16'hAAAA);
        chk("ho_cnt", beat_cnt, 4'd1);
        chk("ho_valid", y_valid, 1'b0);
        chk("ho_data", y_nr_out[15:0], 16'hAAAA);

        // clr after five beats, beat in the clr cycle dropped
        for (int k = 0; k < 4; k++) beat(W'($urandom));
        chk("pre_clr_cnt", beat_cnt, 4'd5);
        clr = 1'b1;
        beat(W'($urandom));
        clr = 1'b0;
        chk("clr_cnt", beat_cnt, 4'd0);
        chk("clr_data", y_nr_out, '0);
        chk("clr_valid", y_valid, 1'b0);
        for (int k = 0; k < BEATS; k++) beat(W'($urandom));
        idle();

        // Async reset while holding a word
        y_ready = 1'b0;
        for (int k = 0; k < BEATS; k++) beat(W'($urandom));
        in_valid = 1'b0;
        chk("ar_full", y_valid, 1'b1);
        #2 rstn = 1'b0;
        #1;
        chk("ar_valid", y_valid, 1'b0);
        chk("ar_data", y_nr_out, '0);
        m_reset();
        @(negedge clk);
        rstn = 1'b1;
        y_ready = 1'b1;
        #1 chk("ar_in_ready", in_ready, 1'b1);
        @(negedge clk);
        idle();

`ifdef SNTC_LDPC_ASM_FRAME_CHK_EN
        for (int k = 0; k < 4; k++) beat(W'($urandom));
        in_valid = 1'b1; in_data = 16'h1234; in_last = 1'b1;
        step();
        chk("fe_pulse", frame_err, 1'b1);
        chk("fe_cnt", beat_cnt, 4'd0);
        chk("fe_valid", y_valid, 1'b0);
        idle();
        chk("fe_once", frame_err, 1'b0);
        for (int k = 0; k < BEATS; k++) beat(W'($urandom));
        chk("fe_recover", y_valid, 1'b1);
        idle();
`endif

        // Partial final beat on the NN=20 instance
        @(negedge clk);
        s_in_valid = 1'b1; s_in_data = 16'hFFFF; s_in_last = 1'b0;
        @(negedge clk);
        chk("small_cnt", s_cnt, 2'd1);
        chk("small_not_valid", s_y_valid, 1'b0);
        chk("small_ready", s_in_ready, 1'b1);
        s_in_last = 1'b1;
        @(negedge clk);
        s_in_valid = 1'b0;
        chk("small_valid", s_y_valid, 1'b1);
        chk("small_word", s_y, 20'hFFFFF);
        chk("small_cnt_wrap", s_cnt, 2'd0);
        @(negedge clk);
        chk("small_drop", s_y_valid, 1'b0);
        chk("small_ferr", s_ferr, 1'b0);

        // Random traffic
        for (int c = 0; c < 3000; c++) begin
            clr = ($urandom_range(0, 63) == 0);
            in_valid = ($urandom_range(0, 3) != 0);
            in_data = W'($urandom);
            y_ready = ($urandom_range(0, 2) != 0);
`ifdef SNTC_LDPC_ASM_FRAME_CHK_EN
            in_last = (m_cnt == BEATS - 1);
            if ($urandom_range(0, 29) == 0) in_last = !in_last;
`else
            in_last = ($urandom_range(0, 1) == 1);
`endif
            step();
        end
        clr = 1'b0;
        in_valid = 1'b0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_n, err_n);
        $finish;
    end
endmodule
